// File: rtl/morse_key_sequencer_pkg.sv
// Shared constants and FSM state encoding for the Morse key sequencer.
// Symbol depth and length-field width default here and feed the top-level parameters.
package morse_key_sequencer_pkg;

   localparam int MAX_MORSE_LEN = 8;
   localparam int MORSE_LEN_W   = $clog2(MAX_MORSE_LEN + 1);

   localparam int DEF_CNT_W          = 5;
   localparam int DEF_DAH_MIN_TICKS  = 3;
   localparam int DEF_CHAR_GAP_TICKS = 3;
   localparam int DEF_WORD_GAP_TICKS = 7;
   localparam int DEF_MARK_MAX_TICKS = 15;
   localparam int DEF_GLITCH_TICKS   = 2;

   typedef enum logic [1:0] {
      MORSE_SEQ_IDLE  = 2'd0,
      MORSE_SEQ_MARK  = 2'd1,
      MORSE_SEQ_SPACE = 2'd2
   } morse_seq_state_e;

endpackage

// File: rtl/morse_key_sequencer_if.sv
// Decoder-side bus: one-clock ce strobe plus the character/word-end payload it qualifies.
interface morse_key_sequencer_if
   import morse_key_sequencer_pkg::*;
#(
   parameter int MAX_LEN = MAX_MORSE_LEN,
   parameter int LEN_W   = MORSE_LEN_W
);
   logic               dec_ce;
   logic [MAX_LEN-1:0] dec_dits_dahs;
   logic [LEN_W-1:0]   dec_len;
   logic               dec_word_end;
   logic               dec_error;

   modport master (
      output dec_ce, dec_dits_dahs, dec_len, dec_word_end, dec_error
   );

   modport slave (
      input dec_ce, dec_dits_dahs, dec_len, dec_word_end, dec_error
   );
endinterface

// File: rtl/morse_key_filter.sv
// Key glitch filter: the filtered level follows the raw key only after it has
// differed for GLITCH_TICKS consecutive ticks.
module morse_key_filter #(
   parameter int GLITCH_TICKS = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic key_raw,
   output logic key_filt
);
   localparam int RUN_W = $clog2(GLITCH_TICKS + 1);

   logic             filt_reg;
   logic [RUN_W-1:0] run_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_reg <= 1'b0;
         run_reg  <= '0;
      end else if (tick) begin
         if (key_raw != filt_reg) begin
            if (run_reg == RUN_W'(GLITCH_TICKS - 1)) begin
               filt_reg <= key_raw;
               run_reg  <= '0;
            end else begin
               run_reg <= run_reg + RUN_W'(1);
            end
         end else begin
            run_reg <= '0;
         end
      end
   end

   assign key_filt = filt_reg;
endmodule

// File: rtl/morse_key_sequencer.sv
// Morse key front end: times marks/spaces on tick, builds the dit/dah symbol and
// strobes characters and word ends to the decoder. Optional MORSE_KEY_GLITCH_FILTER_EN.
module morse_key_sequencer
   import morse_key_sequencer_pkg::*;
#(
   parameter int MAX_LEN        = MAX_MORSE_LEN,
   parameter int LEN_W          = MORSE_LEN_W,
   parameter int CNT_W          = DEF_CNT_W,
   parameter int DAH_MIN_TICKS  = DEF_DAH_MIN_TICKS,
   parameter int CHAR_GAP_TICKS = DEF_CHAR_GAP_TICKS,
   parameter int WORD_GAP_TICKS = DEF_WORD_GAP_TICKS,
   parameter int MARK_MAX_TICKS = DEF_MARK_MAX_TICKS,
   parameter int GLITCH_TICKS   = DEF_GLITCH_TICKS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick,
   input  logic                  key,
   morse_key_sequencer_if.master dec
);
   logic key_level;

`ifdef MORSE_KEY_GLITCH_FILTER_EN
   morse_key_filter #(.GLITCH_TICKS(GLITCH_TICKS)) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .key_raw  (key),
      .key_filt (key_level)
   );
`else
   assign key_level = key;
`endif

   morse_seq_state_e   state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
   logic [MAX_LEN-1:0] sym_reg, sym_next;
   logic [LEN_W-1:0]   sym_len_reg, sym_len_next;
   logic               sym_err_reg, sym_err_next;
   logic               word_open_reg, word_open_next;

   logic               ce_reg, ce_next;
   logic [MAX_LEN-1:0] dits_reg, dits_next;
   logic [LEN_W-1:0]   len_reg, len_next;
   logic               word_end_reg, word_end_next;
   logic               error_reg, error_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= MORSE_SEQ_IDLE;
         cnt_reg       <= '0;
         sym_reg       <= '0;
         sym_len_reg   <= '0;
         sym_err_reg   <= 1'b0;
         word_open_reg <= 1'b0;
         ce_reg        <= 1'b0;
         dits_reg      <= '0;
         len_reg       <= '0;
         word_end_reg  <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         sym_reg       <= sym_next;
         sym_len_reg   <= sym_len_next;
         sym_err_reg   <= sym_err_next;
         word_open_reg <= word_open_next;
         ce_reg        <= ce_next;
         dits_reg      <= dits_next;
         len_reg       <= len_next;
         word_end_reg  <= word_end_next;
         error_reg     <= error_next;
      end
   end

   // Saturating duration count shared by mark and space timing.
   assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      sym_next       = sym_reg;
      sym_len_next   = sym_len_reg;
      sym_err_next   = sym_err_reg;
      word_open_next = word_open_reg;
      ce_next        = 1'b0;
      dits_next      = dits_reg;
      len_next       = len_reg;
      word_end_next  = word_end_reg;
      error_next     = error_reg;

      if (tick) begin
         case (state_reg)
            MORSE_SEQ_IDLE: begin
               if (key_level) begin
                  state_next = MORSE_SEQ_MARK;
                  cnt_next   = CNT_W'(1);
               end
            end
            MORSE_SEQ_MARK: begin
               if (key_level) begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == CNT_W'(MARK_MAX_TICKS)) sym_err_next = 1'b1;
               end else begin
                  if (sym_len_reg < LEN_W'(MAX_LEN)) begin
                     sym_next     = {sym_reg[MAX_LEN-2:0], (cnt_reg >= CNT_W'(DAH_MIN_TICKS))};
                     sym_len_next = sym_len_reg + LEN_W'(1);
                  end else begin
                     sym_err_next = 1'b1;
                  end
                  state_next = MORSE_SEQ_SPACE;
                  cnt_next   = CNT_W'(1);
               end
            end
            MORSE_SEQ_SPACE: begin
               // A new press wins over a gap threshold reached on the same tick.
               if (key_level) begin
                  state_next = MORSE_SEQ_MARK;
                  cnt_next   = CNT_W'(1);
               end else begin
                  cnt_next = cnt_inc;
                  if (cnt_inc == CNT_W'(CHAR_GAP_TICKS) && sym_len_reg != '0) begin
                     ce_next        = 1'b1;
                     word_end_next  = 1'b0;
                     dits_next      = sym_reg;
                     len_next       = sym_len_reg;
                     error_next     = sym_err_reg;
                     sym_next       = '0;
                     sym_len_next   = '0;
                     sym_err_next   = 1'b0;
                     word_open_next = 1'b1;
                  end else if (cnt_inc == CNT_W'(WORD_GAP_TICKS) && word_open_reg) begin
                     ce_next        = 1'b1;
                     word_end_next  = 1'b1;
                     dits_next      = '0;
                     len_next       = '0;
                     error_next     = 1'b0;
                     word_open_next = 1'b0;
                     state_next     = MORSE_SEQ_IDLE;
                     cnt_next       = '0;
                  end
               end
            end
            default: begin
               state_next = MORSE_SEQ_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   assign dec.dec_ce        = ce_reg;
   assign dec.dec_dits_dahs = dits_reg;
   assign dec.dec_len       = len_reg;
   assign dec.dec_word_end  = word_end_reg;
   assign dec.dec_error     = error_reg;
endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench for morse_key_sequencer: directed scenarios plus random keying,
// every tick compared against a mark/space-duration reference model.
module tb_morse_key_sequencer;
   import morse_key_sequencer_pkg::*;

   localparam int MAX_LEN   = MAX_MORSE_LEN;
   localparam int LEN_W     = MORSE_LEN_W;
   localparam int DAH_MIN   = 3;
   localparam int CHAR_GAP  = 3;
   localparam int WORD_GAP  = 7;
   localparam int MARK_MAX  = 15;
   localparam int GLITCH    = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tick = 1'b0;
   logic key = 1'b0;

   morse_key_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dec_bus ();

   morse_key_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .key   (key),
      .dec   (dec_bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit word_end;
      int len;
      int bits;
      bit err;
   } emit_t;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase 0 idle, 1 in a mark, 2 in a space; elements held as a queue.
   int    m_phase;
   int    m_mark;
   int    m_space;
   bit    m_elems[$];
   bit    m_err;
   bit    m_open;
   bit    m_filt;
   int    m_run;
   emit_t last_exp;
   emit_t last_char;
   int    n_char;
   int    n_word;

   task automatic model_reset();
      m_phase = 0; m_mark = 0; m_space = 0;
      m_elems.delete();
      m_err = 0; m_open = 0; m_filt = 0; m_run = 0;
      last_exp = '{0, 0, 0, 0};
   endtask

   function automatic bit model_step(input bit k, output emit_t e);
      bit lvl;
      bit hit;
      hit = 0;
      e = '{0, 0, 0, 0};
`ifdef MORSE_KEY_GLITCH_FILTER_EN
      lvl = m_filt;
      if (k != m_filt) begin
         m_run++;
         if (m_run == GLITCH) begin
            m_filt = k;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
`else
      lvl = k;
`endif
      case (m_phase)
         0: if (lvl) begin m_phase = 1; m_mark = 1; end
         1: begin
            if (lvl) begin
               m_mark++;
               if (m_mark == MARK_MAX) m_err = 1;
            end else begin
               if (m_elems.size() < MAX_LEN) m_elems.push_back(m_mark >= DAH_MIN);
               else m_err = 1;
               m_phase = 2;
               m_space = 1;
            end
         end
         default: begin
            if (lvl) begin
               m_phase = 1;
               m_mark = 1;
            end else begin
               m_space++;
               if (m_space == CHAR_GAP && m_elems.size() > 0) begin
                  hit = 1;
                  e.len = m_elems.size();
                  foreach (m_elems[i]) e.bits = (e.bits << 1) | int'(m_elems[i]);
                  e.err = m_err;
                  m_elems.delete();
                  m_err = 0;
                  m_open = 1;
               end else if (m_space == WORD_GAP && m_open) begin
                  hit = 1;
                  e.word_end = 1;
                  m_open = 0;
                  m_phase = 0;
               end
            end
         end
      endcase
      return hit;
   endfunction

   task automatic check_hold(input string tag);
      n_tests++;
      if (dec_bus.dec_ce !== 1'b0 || dec_bus.dec_word_end !== last_exp.word_end ||
          int'(dec_bus.dec_len) != last_exp.len || int'(dec_bus.dec_dits_dahs) != last_exp.bits ||
          dec_bus.dec_error !== last_exp.err) begin
         n_fail++;
         $display("FAIL %s: got ce=%0b we=%0b len=%0d bits=%0h err=%0b, want ce=0 we=%0b len=%0d bits=%0h err=%0b",
                  tag, dec_bus.dec_ce, dec_bus.dec_word_end, dec_bus.dec_len, dec_bus.dec_dits_dahs,
                  dec_bus.dec_error, last_exp.word_end, last_exp.len, last_exp.bits, last_exp.err);
      end
   endtask

   // One tick period: tick high for one clock, then three idle clocks.
   task automatic do_tick(input bit k);
      emit_t exp;
      bit    exp_v;
      key = k;
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      exp_v = model_step(k, exp);
      n_tests++;
      if (dec_bus.dec_ce !== exp_v) begin
         n_fail++;
         $display("FAIL strobe_timing: dec_ce=%0b expected %0b (key=%0b)", dec_bus.dec_ce, exp_v, k);
      end else if (exp_v) begin
         n_tests++;
         if (dec_bus.dec_word_end !== exp.word_end || int'(dec_bus.dec_len) != exp.len ||
             int'(dec_bus.dec_dits_dahs) != exp.bits || dec_bus.dec_error !== exp.err) begin
            n_fail++;
            $display("FAIL payload: got we=%0b len=%0d bits=%0h err=%0b, want we=%0b len=%0d bits=%0h err=%0b",
                     dec_bus.dec_word_end, dec_bus.dec_len, dec_bus.dec_dits_dahs, dec_bus.dec_error,
                     exp.word_end, exp.len, exp.bits, exp.err);
         end
      end
      if (dec_bus.dec_ce === 1'b1) begin
         $display("[TB] t=%0t strobe we=%0b len=%0d bits=%0h err=%0b", $time, dec_bus.dec_word_end,
                  dec_bus.dec_len, dec_bus.dec_dits_dahs, dec_bus.dec_error);
         if (dec_bus.dec_word_end === 1'b1) n_word++;
         else begin
            n_char++;
            last_char = '{0, int'(dec_bus.dec_len), int'(dec_bus.dec_dits_dahs), dec_bus.dec_error};
         end
      end
      if (exp_v) last_exp = exp;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_hold("hold_between_ticks");
      end
   endtask

   task automatic run(input bit k, input int n);
      for (int i = 0; i < n; i++) do_tick(k);
   endtask

   task automatic check_char(input string tag, input int c0, input int len, input int bits, input bit err);
      n_tests++;
      if (n_char != c0 + 1 || last_char.len != len || last_char.bits != bits || last_char.err != err) begin
         n_fail++;
         $display("FAIL %s: chars=%0d len=%0d bits=%0h err=%0b, want chars=%0d len=%0d bits=%0h err=%0b",
                  tag, n_char - c0, last_char.len, last_char.bits, last_char.err, 1, len, bits, err);
      end
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_hold("reset_outputs");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_hold("post_reset_outputs");
   endtask

   task automatic test_letter_a();
      int c0, w0;
      c0 = n_char; w0 = n_word;
      run(1, 1); run(0, 1); run(1, 3); run(0, 3);
`ifndef MORSE_KEY_GLITCH_FILTER_EN
      check_char("letter_a", c0, 2, 1, 0);
`endif
      run(0, 4);
`ifndef MORSE_KEY_GLITCH_FILTER_EN
      n_tests++;
      if (n_word != w0 + 1 || dec_bus.dec_word_end !== 1'b1) begin
         n_fail++;
         $display("FAIL word_end: words=%0d we=%0b, want words=1 we=1", n_word - w0, dec_bus.dec_word_end);
      end
`endif
      run(0, 8);
   endtask

   task automatic test_overflow();
      int c0;
      c0 = n_char;
      for (int i = 0; i < MAX_LEN + 1; i++) begin
         run(1, 1);
         run(0, 1);
      end
      run(0, 2);
`ifndef MORSE_KEY_GLITCH_FILTER_EN
      check_char("overflow", c0, MAX_LEN, 0, 1);
`endif
      run(0, 8);
   endtask

   task automatic test_stuck_key();
      int c0;
      c0 = n_char;
      run(1, MARK_MAX); run(0, 3);
`ifndef MORSE_KEY_GLITCH_FILTER_EN
      check_char("stuck_key", c0, 1, 1, 1);
`endif
      run(0, 8);
   endtask

   task automatic test_priority();
      int c0;
      c0 = n_char;
      run(1, 1); run(0, 2); run(1, 1); run(0, 3);
`ifndef MORSE_KEY_GLITCH_FILTER_EN
      check_char("priority", c0, 2, 0, 0);
`endif
      run(0, 8);
   endtask

   task automatic test_reset_mid();
      int c0;
      run(1, 1); run(0, 1); run(1, 1); run(0, 1); run(1, 2);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_hold("async_reset_clear");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      c0 = n_char;
      run(1, 1); run(0, 3);
`ifndef MORSE_KEY_GLITCH_FILTER_EN
      check_char("after_reset", c0, 1, 0, 0);
`endif
      run(0, 8);
   endtask

`ifdef MORSE_KEY_GLITCH_FILTER_EN
   task automatic test_glitch();
      int c0;
      c0 = n_char;
      run(1, 1); run(0, 10);
      n_tests++;
      if (n_char != c0) begin
         n_fail++;
         $display("FAIL glitch_pulse: chars=%0d want 0", n_char - c0);
      end
      run(1, 3); run(0, 12);
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) run(1, $urandom_range(14, 18));
         else run(1, $urandom_range(1, 5));
         run(0, $urandom_range(1, 9));
      end
      run(0, 10);
   endtask

   initial begin
      n_char = 0;
      n_word = 0;
      test_reset();
      test_letter_a();
      test_overflow();
      test_stuck_key();
      test_priority();
      test_reset_mid();
`ifdef MORSE_KEY_GLITCH_FILTER_EN
      test_glitch();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
